param_fifo: RTL and testbench
=============================

# param_fifo

Parametrised synchronous single-clock FIFO that replaces the fixed 8×8 FIFO in the datapath staging between producer and consumer blocks. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It also accepts simultaneous read and write when full, and offers an optional first-word-fall-through output mode.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wren  in  1  write request
- i_data  in  DATA_W  write data
- rden  in  1  read request; in FWFT builds this is the pop/acknowledge
- clr_err  in  1  clears overflow and underflow
- o_data  out  DATA_W  read data
- o_valid  out  1  o_data holds a valid word (see Operation)
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - The low bits index the memory; the MSB distinguishes full from empty.
- Combinational flags:
  - count = wptr − rptr
  - empty = (count==0); full = (count==DEPTH)
  - almost_full and almost_empty are combinational from count.
- Write acceptance: wr_ok = wren && (!full || rd_ok).
  - When full, a simultaneous accepted read frees the slot, so the write is accepted.
- Read acceptance: rd_ok = rden && !empty.
  - When empty, a simultaneous write does not make the read succeed; the read is rejected.
- Error flags:
  - overflow sets on wren && !wr_ok.
  - underflow sets on rden && !rd_ok.
  - Both hold until a clr_err cycle with no new error. If a set and clr_err occur in the same cycle, set wins.
- Standard mode (macro absent):
  - On rd_ok, o_data ← mem[rptr] at the edge, and o_valid is 1 for exactly the following cycle.
  - Otherwise o_valid is 0 and o_data holds its last value.
- Reset values: both pointers 0, o_data 0, o_valid 0, overflow 0, underflow 0.
  - Resulting outputs: count 0, empty 1, full 0, almost_empty 1 (for AE_THRESH≥0), almost_full 0.
- Reset mid-operation discards all contents immediately. Memory contents are not cleared.

## Timing
- Write at edge N:
  - count, the flags, and (in FWFT mode) o_data/o_valid reflect it after edge N.
- Standard read latency is 1 cycle: rden sampled at edge N, data valid during cycle N+1.
- Back-to-back reads every cycle sustain full throughput; o_valid stays high continuously.
- Simultaneous rd_ok and wr_ok leave count unchanged.
- Flags have no lookahead. A producer must stop at full, or at almost_full with AF_THRESH margin for pipelined sources.

## Configuration
- PARAM_FIFO_FWFT_EN defined (first-word-fall-through mode):
  - o_data = mem[rptr] combinationally and o_valid = !empty.
  - rden pops the presented word at the edge; the next word, if any, appears after that edge.
  - Read latency is 0.
  - The o_data register is removed; o_data is don't-care while o_valid=0.
- Macro undefined: the standard registered-output behaviour above.
- Flags, count and the error logic are identical in both modes.

## Structure
- Package param_fifo_pkg holds:
  - the pointer-width helper function (clog2-based)
  - default parameter constants PARAM_FIFO_DEF_DATA_W=8 and PARAM_FIFO_DEF_DEPTH=8
- One sub-module, fifo_mem:
  - simple dual-port DEPTH×DATA_W array with a synchronous write port and an asynchronous read address
  - the top instantiates it and adds the standard-mode output register
- Elaboration-time checks: DEPTH is a power of two; AE_THRESH < AF_THRESH ≤ DEPTH.

## Test plan
- Fill from reset, DEPTH=8, writing 0x01..0x08 on consecutive cycles:
  - count goes 1..8
  - almost_full rises when count reaches 7; full rises after the 8th write
  - a 9th wren sets overflow, and count stays 8.
- Drain a full FIFO with 8 consecutive rden:
  - standard mode: o_data = 0x01..0x08 on cycles N+1..N+8 with o_valid high throughout
  - empty rises after the 8th read; a 9th rden sets underflow.
- Full + simultaneous wren/rden writing 0xAA:
  - both are accepted, count stays 8, overflow stays 0
  - 0xAA is read out last.
- Empty + simultaneous wren(0x55)/rden:
  - the read is rejected, underflow=1, count=1
  - the next rden returns 0x55.
- Pointer wrap: run 20 write/read pairs with the data equal to the index:
  - every output matches, in order, across a wrap.
- Error-flag clearing:
  - assert clr_err alone → overflow and underflow clear
  - clr_err in the same cycle as a rejected write → overflow stays 1.
- Reset mid-fill (count=5): assert rst_n low asynchronously between edges:
  - count=0, empty=1, and o_valid=0 immediately.
- FWFT build: write 0x3C to an empty FIFO:
  - o_valid=1 and o_data=0x3C after that edge with no rden
  - rden pops it and empty returns to 1.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
// Holds the default widths and the pointer-width function.
package param_fifo_pkg;

    localparam int PARAM_FIFO_DEF_DATA_W = 8;
    localparam int PARAM_FIFO_DEF_DEPTH  = 8;

    // Pointer width: one extra MSB beyond the index bits
    // separates the full state from the empty state.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// Simple dual-port DEPTH x DATA_W storage array for param_fifo.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module fifo_mem
    import param_fifo_pkg::*;
#(
    parameter int DATA_W = PARAM_FIFO_DEF_DATA_W,
    parameter int DEPTH  = PARAM_FIFO_DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with thresholds, count and sticky errors.
// Ports: clk, rst_n (async low), wren/i_data, rden, clr_err, o_data/o_valid,
//        full, empty, almost_full, almost_empty, count, overflow, underflow.
// Build option: define PARAM_FIFO_FWFT_EN for first-word-fall-through output.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_W    = PARAM_FIFO_DEF_DATA_W,
    parameter int DEPTH     = PARAM_FIFO_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wren,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    rden,
    input  logic                    clr_err,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ptr_w(DEPTH)-1:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (DATA_W < 1) begin : g_chk_w
        $error("param_fifo: DATA_W must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_d
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_t
        $error("param_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] mem_rdata;

    assign count        = wptr - rptr;
    assign empty        = (count == '0);
    assign full         = (count == PW'(DEPTH));
    assign almost_full  = (count >= PW'(AF_THRESH));
    assign almost_empty = (count <= PW'(AE_THRESH));

    // A read on a full FIFO frees a slot in the same cycle, so the
    // write is still taken; a write into an empty FIFO cannot feed
    // a read in the same cycle.
    assign rd_ok = rden && !empty;
    assign wr_ok = wren && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky errors: a new error in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wren && !wr_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rden && !rd_ok) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_ok),
        .waddr  (wptr[AW-1:0]),
        .wdata  (i_data),
        .raddr  (rptr[AW-1:0]),
        .rdata  (mem_rdata)
    );

`ifdef PARAM_FIFO_FWFT_EN
    // Head of queue is presented directly; rden acknowledges it.
    assign o_data  = mem_rdata;
    assign o_valid = !empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= rd_ok;
            if (rd_ok) begin
                o_data <= mem_rdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DEPTH=8, DATA_W=8).
// Reference model is a queue of words plus sticky error bits.
module tb_param_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk;
    logic          rst_n;
    logic          wren;
    logic [DW-1:0] i_data;
    logic          rden;
    logic          clr_err;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    param_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .AF_THRESH (DP - 1),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wren         (wren),
        .i_data       (i_data),
        .rden         (rden),
        .clr_err      (clr_err),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_udf;
    logic [DW-1:0] m_data;
    logic          m_valid;

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    // Apply one cycle of stimulus and advance the model; returns
    // #1 after the active edge with inputs back to idle.
    task automatic drive(input logic wr, input logic [DW-1:0] d,
                         input logic rd, input logic clr);
        bit mf, me, rok, wok;
        wren = wr; i_data = d; rden = rd; clr_err = clr;
        @(posedge clk);
        mf  = (q.size() == DP);
        me  = (q.size() == 0);
        rok = rd && !me;
        wok = wr && (!mf || rok);
        if (wr && !wok) m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
        if (rd && !rok) m_udf = 1'b1;
        else if (clr)   m_udf = 1'b0;
        if (rok) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wok) q.push_back(d);
`ifdef PARAM_FIFO_FWFT_EN
        m_valid = (q.size() != 0);
        if (m_valid) m_data = q[0];
`endif
        #1;
        wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        vectors++;
        if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_flags: got e%b f%b ae%b af%b want e1 f0 ae1 af0",
                     empty, full, almost_empty, almost_full);
        end
        vectors++;
        if ({overflow, underflow, o_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_err_valid: got ovf%b udf%b v%b want 0 0 0",
                     overflow, underflow, o_valid);
        end
`ifndef PARAM_FIFO_FWFT_EN
        vectors++;
        if (o_data !== 8'h00) begin
            errors++; $display("FAIL reset_odata: got %h want 00", o_data);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DP; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            vectors++;
            if (count !== 4'(i)) begin
                errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, i);
            end
            vectors++;
            if (almost_full !== (i >= 7) || full !== (i == 8)) begin
                errors++;
                $display("FAIL fill_flags%0d: got af%b f%b want af%b f%b",
                         i, almost_full, full, i >= 7, i == 8);
            end
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_ovf: got ovf%b cnt%0d want ovf1 cnt8", overflow, count);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_drain();
        for (int i = 0; i < DP; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
            vectors++;
            if (o_valid !== 1'b1 || o_data !== DW'(i + 1)) begin
                errors++;
                $display("FAIL drain_head%0d: got v%b %h want v1 %h",
                         i, o_valid, o_data, DW'(i + 1));
            end
            drive(1'b0, '0, 1'b1, 1'b0);
`else
            drive(1'b0, '0, 1'b1, 1'b0);
            vectors++;
            if (o_valid !== 1'b1 || o_data !== DW'(i + 1)) begin
                errors++;
                $display("FAIL drain_data%0d: got v%b %h want v1 %h",
                         i, o_valid, o_data, DW'(i + 1));
            end
`endif
        end
        vectors++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL drain_empty: got e%b cnt%0d want e1 cnt0", empty, count);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_udf: got udf%b v%b want udf1 v0", underflow, o_valid);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] last;
        for (int i = 0; i < DP; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_simul: got cnt%0d ovf%b f%b want cnt8 ovf0 f1",
                     count, overflow, full);
        end
        last = '0;
        for (int i = 0; i < DP; i++) begin
`ifdef PARAM_FIFO_FWFT_EN
            last = o_data;
            drive(1'b0, '0, 1'b1, 1'b0);
`else
            drive(1'b0, '0, 1'b1, 1'b0);
            last = o_data;
`endif
        end
        vectors++;
        if (last !== 8'hAA) begin
            errors++; $display("FAIL full_simul_last: got %h want aa", last);
        end
    endtask

    task automatic test_empty_simul();
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL empty_simul: got udf%b cnt%0d want udf1 cnt1", underflow, count);
        end
`ifdef PARAM_FIFO_FWFT_EN
        vectors++;
        if (o_data !== 8'h55 || o_valid !== 1'b1) begin
            errors++; $display("FAIL empty_simul_rd: got v%b %h want v1 55", o_valid, o_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
`else
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (o_data !== 8'h55 || o_valid !== 1'b1) begin
            errors++; $display("FAIL empty_simul_rd: got v%b %h want v1 55", o_valid, o_data);
        end
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
`ifdef PARAM_FIFO_FWFT_EN
            vectors++;
            if (o_data !== DW'(i) || o_valid !== 1'b1) begin
                errors++; $display("FAIL wrap%0d: got v%b %h want v1 %h", i, o_valid, o_data, DW'(i));
            end
            drive(1'b0, '0, 1'b1, 1'b0);
`else
            drive(1'b0, '0, 1'b1, 1'b0);
            vectors++;
            if (o_data !== DW'(i) || o_valid !== 1'b1) begin
                errors++; $display("FAIL wrap%0d: got v%b %h want v1 %h", i, o_valid, o_data, DW'(i));
            end
`endif
        end
    endtask

    task automatic test_clr();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DP; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++; $display("FAIL clr_setup: got ovf%b udf%b want 1 1", overflow, underflow);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL clr_alone: got ovf%b udf%b want 0 0", overflow, underflow);
        end
        drive(1'b1, 8'h78, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++; $display("FAIL clr_set_wins: got ovf%b udf%b want 1 0", overflow, underflow);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 99) < 55), DW'($urandom),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
            vectors++;
            if (count !== 4'(q.size()) || full !== (q.size() == DP) ||
                empty !== (q.size() == 0) || almost_full !== (q.size() >= DP - 1) ||
                almost_empty !== (q.size() <= 1)) begin
                errors++;
                $display("FAIL rand_flags@%0d: got cnt%0d f%b e%b af%b ae%b want cnt%0d",
                         n, count, full, empty, almost_full, almost_empty, q.size());
            end
            vectors++;
            if (overflow !== m_ovf || underflow !== m_udf || o_valid !== m_valid ||
                (m_valid && o_data !== m_data)) begin
                errors++;
                $display("FAIL rand_out@%0d: got ovf%b udf%b v%b %h want ovf%b udf%b v%b %h",
                         n, overflow, underflow, o_valid, o_data, m_ovf, m_udf, m_valid, m_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; #1; rst_n = 1'b1; #1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(i + 16), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (count !== 4'd5 || o_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got cnt%0d v%b want cnt5 v1", count, o_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 4'd0 || empty !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid: got cnt%0d e%b v%b want cnt0 e1 v0", count, empty, o_valid);
        end
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef PARAM_FIFO_FWFT_EN
    task automatic test_fwft();
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        vectors++;
        if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
            errors++; $display("FAIL fwft_show: got v%b %h want v1 3c", o_valid, o_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (empty !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL fwft_pop: got e%b v%b want e1 v0", empty, o_valid);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; i_data = '0;
        model_reset();
        #22 rst_n = 1'b1;
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_clr();
        test_reset_mid();
`ifdef PARAM_FIFO_FWFT_EN
        test_fwft();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
